// File: rtl/data_break_arbiter.sv
// Data-break (DMA) arbiter: picks one requesting device, waits for a CPU break
// slot, runs exactly one memory cycle for it, then returns a one-cycle ack.
module data_break_arbiter #(
  parameter int NREQ = 4,
  parameter int RR   = 0
) (
  input  logic                 clk100,
  input  logic                 reset,
  input  logic                 cleard,
  input  logic [NREQ-1:0]      breq,
  input  logic [NREQ-1:0]      bwrite,
  input  logic [0:15*NREQ-1]   baddr,
  input  logic [0:12*NREQ-1]   bwdata,
  output logic [NREQ-1:0]      bgrant,
  output logic [NREQ-1:0]      back,
  output logic [0:11]          brdata,
  output logic                 data_break,
  input  logic                 break_slot,
  output logic                 break_in_prog,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [0:14]          mem_addr,
  output logic [0:11]          mem_wdata,
  input  logic [0:11]          mem_rdata,
  input  logic                 mem_ack
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, ARB, WAIT_SLOT, MEM, DONE} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   win, last, arb_win, cur_win, scan;
  logic            arb_hit, in_break_n;
  logic [14:0]     lat_addr;
  logic [11:0]     lat_wdata;
  logic            lat_we;
  logic [14:0]     dev_addr  [NREQ];
  logic [11:0]     dev_wdata [NREQ];

  // Device i's fields sit at ascending bit offsets; bit 0 of each field is its MSB.
  for (genvar i = 0; i < NREQ; i++) begin : g_dev
    assign dev_addr[i]  = baddr[15*i +: 15];
    assign dev_wdata[i] = bwdata[12*i +: 12];
  end

  always_comb begin
    arb_win = '0;
    arb_hit = 1'b0;
    scan    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = (RR != 0) ? IW'((int'(last) + 1 + k) % NREQ) : IW'(k);
      if (!arb_hit && breq[scan]) begin
        arb_hit = 1'b1;
        arb_win = scan;
      end
    end
  end

  assign cur_win = (state == ARB) ? arb_win : win;

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (|breq) state_n = ARB;
      ARB:       state_n = (cleard || !arb_hit) ? IDLE : WAIT_SLOT;
      WAIT_SLOT: begin
        if (cleard || !breq[win]) state_n = IDLE;
        else if (break_slot)      state_n = MEM;
      end
      MEM:       if (mem_ack) state_n = DONE;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  assign in_break_n = (state_n == WAIT_SLOT) || (state_n == MEM);

  // All outputs are registered from the next state so they never glitch.
  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      win           <= '0;
      last          <= IW'(NREQ - 1);
      lat_addr      <= '0;
      lat_wdata     <= '0;
      lat_we        <= 1'b0;
      bgrant        <= '0;
      back          <= '0;
      brdata        <= '0;
      data_break    <= 1'b0;
      break_in_prog <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      if (state == ARB) begin
        win       <= arb_win;
        lat_addr  <= dev_addr[arb_win];
        lat_wdata <= dev_wdata[arb_win];
        lat_we    <= bwrite[arb_win];
      end
      if (state == DONE) last <= win;
      bgrant        <= in_break_n ? (NREQ'(1) << cur_win) : '0;
      data_break    <= in_break_n;
      back          <= (state_n == DONE) ? (NREQ'(1) << win) : '0;
      mem_req       <= (state_n == MEM);
      break_in_prog <= (state_n == MEM);
      mem_we        <= (state_n == MEM) && lat_we;
      mem_addr      <= (state_n == MEM) ? lat_addr  : '0;
      mem_wdata     <= (state_n == MEM) ? lat_wdata : '0;
      if (state == MEM && mem_ack && !lat_we) brdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_data_break_arbiter.sv
// Scoreboard bench: instance 0 is fixed priority, instance 1 is round-robin;
// both see the same stimulus, each with its own device and memory model.
module tb_data_break_arbiter;
  localparam int N = 4;

  typedef struct {
    int          dev;
    logic        we;
    logic [14:0] addr;
    logic [11:0] wd;
    logic [11:0] rd;
  } exp_t;

  logic           clk100 = 1'b0;
  logic           reset, cleard, break_slot;
  logic [N-1:0]   bwrite;
  logic [0:15*N-1] baddr;
  logic [0:12*N-1] bwdata;

  logic [N-1:0]   breq [2], bgrant [2], back [2], rearm [2];
  logic [0:11]    brdata [2], mem_wdata [2], mem_rdata [2];
  logic [0:14]    mem_addr [2];
  logic           data_break [2], bip [2], mem_req [2], mem_we [2], mem_ack [2];

  exp_t q0[$], q1[$];
  exp_t mon_e;
  int n_cmp = 0, n_err = 0, cyc = 0, ack_dly = 0;
  int mcnt [2];
  int last_back [2];

  logic [14:0] addr_tab [4] = '{15'o00100, 15'o00200, 15'o00300, 15'o00400};
  logic [11:0] rd_tab   [4] = '{12'o7677, 12'o7577, 12'o7477, 12'o7377};

  always #5 clk100 = ~clk100;
  always @(posedge clk100) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    data_break_arbiter #(.NREQ(N), .RR(g)) u_dut (
      .clk100(clk100), .reset(reset), .cleard(cleard),
      .breq(breq[g]), .bwrite(bwrite), .baddr(baddr), .bwdata(bwdata),
      .bgrant(bgrant[g]), .back(back[g]), .brdata(brdata[g]),
      .data_break(data_break[g]), .break_slot(break_slot),
      .break_in_prog(bip[g]), .mem_req(mem_req[g]), .mem_we(mem_we[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]), .mem_ack(mem_ack[g]));
  end

  // Memory contents: one marked word, everything else is the inverted low address.
  function automatic logic [11:0] rd_of(logic [14:0] a);
    return (a == 15'o01234) ? 12'o7070 : (a[11:0] ^ 12'o7777);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(string nm, string msg);
    n_cmp++;
    n_err++;
    $display("FAIL %s: %s (cycle %0d)", nm, msg, cyc);
  endtask

  task automatic push(int g, int dev, logic we, logic [14:0] a, logic [11:0] wd, logic [11:0] rd);
    exp_t e;
    e.dev = dev; e.we = we; e.addr = a; e.wd = wd; e.rd = rd;
    if (g == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic set_dev(int i, logic we, logic [14:0] a, logic [11:0] wd);
    bwrite[i]        = we;
    baddr[15*i +: 15] = a;
    bwdata[12*i +: 12] = wd;
  endtask

  task automatic mem_check(int g);
    exp_t e;
    if ((g == 0 ? q0.size() : q1.size()) == 0) begin
      fail($sformatf("mem_unexpected[%0d]", g), $sformatf("access to 0x%0h", mem_addr[g]));
    end else begin
      e = (g == 0) ? q0[0] : q1[0];
      chk($sformatf("mem_addr[%0d]", g), 32'(mem_addr[g]), 32'(e.addr));
      chk($sformatf("mem_we[%0d]", g), 32'(mem_we[g]), 32'(e.we));
      if (e.we) chk($sformatf("mem_wdata[%0d]", g), 32'(mem_wdata[g]), 32'(e.wd));
    end
  endtask

  // One cycle: devices drop acked requests, memory answers after ack_dly cycles.
  task automatic tick();
    @(negedge clk100);
    for (int g = 0; g < 2; g++) begin
      breq[g]  = breq[g] & ~(back[g] & ~rearm[g]);
      rearm[g] = rearm[g] & ~back[g];
      if (mem_req[g] === 1'b1) begin
        if (mcnt[g] == ack_dly) begin
          mem_ack[g]   = 1'b1;
          mem_rdata[g] = rd_of(mem_addr[g]);
          mem_check(g);
        end else begin
          mem_ack[g] = 1'b0;
        end
        mcnt[g]++;
      end else begin
        mem_ack[g] = 1'b0;
        mcnt[g]    = 0;
      end
    end
  endtask

  task automatic drain(int lim);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < lim) begin
      tick();
      n++;
    end
    if (q0.size() + q1.size() != 0)
      fail("drain_timeout", $sformatf("%0d/%0d breaks never acked", q0.size(), q1.size()));
    q0.delete();
    q1.delete();
    repeat (3) tick();
  endtask

  always @(negedge clk100) begin
    for (int g = 0; g < 2; g++) begin
      if ((|back[g]) === 1'b1) begin
        if ((g == 0 ? q0.size() : q1.size()) == 0) begin
          fail($sformatf("back_unexpected[%0d]", g), $sformatf("back=%b", back[g]));
        end else begin
          if (g == 0) mon_e = q0.pop_front();
          else        mon_e = q1.pop_front();
          chk($sformatf("back[%0d]", g), 32'(back[g]), 32'(1) << mon_e.dev);
          chk($sformatf("brdata[%0d]", g), 32'(brdata[g]), 32'(mon_e.rd));
          if (last_back[g] >= 0)
            chk($sformatf("back_gap[%0d]", g), 32'((cyc - last_back[g]) >= 3), 32'(1));
          last_back[g] = cyc;
        end
      end
    end
  end

  initial begin
    reset = 1'b1; cleard = 1'b0; break_slot = 1'b0;
    bwrite = '0; baddr = '0; bwdata = '0;
    for (int g = 0; g < 2; g++) begin
      breq[g] = '0; rearm[g] = '0; mem_ack[g] = 1'b0; mem_rdata[g] = '0;
      mcnt[g] = 0; last_back[g] = -1;
    end
    repeat (3) @(negedge clk100);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_bgrant[%0d]", g), 32'(bgrant[g]), 0);
      chk($sformatf("rst_back[%0d]", g), 32'(back[g]), 0);
      chk($sformatf("rst_brdata[%0d]", g), 32'(brdata[g]), 0);
      chk($sformatf("rst_dbreak[%0d]", g), 32'(data_break[g]), 0);
      chk($sformatf("rst_memreq[%0d]", g), 32'(mem_req[g]), 0);
      chk($sformatf("rst_bip[%0d]", g), 32'(bip[g]), 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_dev(i, 1'b0, addr_tab[i], 12'o0);
    break_slot = 1'b1;

    // All four held, dev0 re-requests once: fixed 0,0,1,2,3 / round-robin 0,1,2,3,0.
    push(0, 0, 0, addr_tab[0], 0, rd_tab[0]); push(0, 0, 0, addr_tab[0], 0, rd_tab[0]);
    push(0, 1, 0, addr_tab[1], 0, rd_tab[1]); push(0, 2, 0, addr_tab[2], 0, rd_tab[2]);
    push(0, 3, 0, addr_tab[3], 0, rd_tab[3]);
    push(1, 0, 0, addr_tab[0], 0, rd_tab[0]); push(1, 1, 0, addr_tab[1], 0, rd_tab[1]);
    push(1, 2, 0, addr_tab[2], 0, rd_tab[2]); push(1, 3, 0, addr_tab[3], 0, rd_tab[3]);
    push(1, 0, 0, addr_tab[0], 0, rd_tab[0]);
    for (int g = 0; g < 2; g++) begin rearm[g] = 4'b0001; breq[g] = 4'b1111; end
    drain(300);

    // Simultaneous 0110: dev1 then dev2 on both.
    for (int g = 0; g < 2; g++) begin
      push(g, 1, 0, addr_tab[1], 0, rd_tab[1]); push(g, 2, 0, addr_tab[2], 0, rd_tab[2]);
      breq[g] = 4'b0110;
    end
    drain(200);

    // dev1 alone leaves the round-robin pointer at 1; then 0011 serves dev0 first.
    for (int g = 0; g < 2; g++) begin push(g, 1, 0, addr_tab[1], 0, rd_tab[1]); breq[g] = 4'b0010; end
    drain(100);
    for (int g = 0; g < 2; g++) begin
      push(g, 0, 0, addr_tab[0], 0, rd_tab[0]); push(g, 1, 0, addr_tab[1], 0, rd_tab[1]);
      breq[g] = 4'b0011;
    end
    drain(200);

    // Single read with latency check.
    set_dev(0, 1'b0, 15'o01234, 12'o0);
    for (int g = 0; g < 2; g++) begin push(g, 0, 0, 15'o01234, 0, 12'o7070); breq[g] = 4'b0001; end
    tick();
    for (int g = 0; g < 2; g++) chk($sformatf("lat1_dbreak[%0d]", g), 32'(data_break[g]), 0);
    tick();
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("lat2_bgrant[%0d]", g), 32'(bgrant[g]), 32'h1);
      chk($sformatf("lat2_memreq[%0d]", g), 32'(mem_req[g]), 0);
    end
    tick();
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("lat3_memreq[%0d]", g), 32'(mem_req[g]), 1);
      chk($sformatf("lat3_bip[%0d]", g), 32'(bip[g]), 1);
    end
    drain(100);

    // Write with break_slot held low for 10 cycles; brdata must keep 7070.
    set_dev(2, 1'b1, 15'o70000, 12'o4321);
    break_slot = 1'b0;
    for (int g = 0; g < 2; g++) begin push(g, 2, 1, 15'o70000, 12'o4321, 12'o7070); breq[g] = 4'b0100; end
    tick(); tick();
    repeat (10) begin
      tick();
      for (int g = 0; g < 2; g++) begin
        chk($sformatf("slot_wait_dbreak[%0d]", g), 32'(data_break[g]), 1);
        chk($sformatf("slot_wait_memreq[%0d]", g), 32'(mem_req[g]), 0);
      end
    end
    break_slot = 1'b1;
    drain(100);
    set_dev(2, 1'b0, addr_tab[2], 12'o0);

    // Withdraw in WAIT_SLOT.
    break_slot = 1'b0;
    for (int g = 0; g < 2; g++) breq[g] = 4'b1000;
    repeat (3) tick();
    for (int g = 0; g < 2; g++) chk($sformatf("wd_bgrant[%0d]", g), 32'(bgrant[g]), 32'h8);
    for (int g = 0; g < 2; g++) breq[g] = 4'b0000;
    tick();
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("wd_drop_bgrant[%0d]", g), 32'(bgrant[g]), 0);
      chk($sformatf("wd_drop_dbreak[%0d]", g), 32'(data_break[g]), 0);
    end
    break_slot = 1'b1;
    repeat (5) tick();

    // cleard in WAIT_SLOT.
    break_slot = 1'b0;
    for (int g = 0; g < 2; g++) breq[g] = 4'b1000;
    repeat (3) tick();
    cleard = 1'b1;
    tick();
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("clr_bgrant[%0d]", g), 32'(bgrant[g]), 0);
      chk($sformatf("clr_dbreak[%0d]", g), 32'(data_break[g]), 0);
      breq[g] = 4'b0000;
    end
    cleard = 1'b0;
    break_slot = 1'b1;
    repeat (5) tick();

    // cleard during MEM with a slow memory: the cycle still completes.
    ack_dly = 5;
    for (int g = 0; g < 2; g++) begin push(g, 1, 0, addr_tab[1], 0, rd_tab[1]); breq[g] = 4'b0010; end
    repeat (3) tick();
    cleard = 1'b1;
    tick(); tick();
    for (int g = 0; g < 2; g++) chk($sformatf("clrmem_memreq[%0d]", g), 32'(mem_req[g]), 1);
    cleard = 1'b0;
    drain(100);

    // Asynchronous reset in the middle of MEM.
    ack_dly = 50;
    for (int g = 0; g < 2; g++) breq[g] = 4'b0100;
    repeat (3) tick();
    for (int g = 0; g < 2; g++) chk($sformatf("rstmem_pre[%0d]", g), 32'(mem_req[g]), 1);
    #2 reset = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rstmem_memreq[%0d]", g), 32'(mem_req[g]), 0);
      chk($sformatf("rstmem_bgrant[%0d]", g), 32'(bgrant[g]), 0);
      chk($sformatf("rstmem_dbreak[%0d]", g), 32'(data_break[g]), 0);
      chk($sformatf("rstmem_brdata[%0d]", g), 32'(brdata[g]), 0);
      breq[g] = 4'b0000;
    end
    #1 reset = 1'b0;
    ack_dly = 0;
    repeat (5) tick();
    for (int g = 0; g < 2; g++) chk($sformatf("rstmem_after[%0d]", g), 32'(mem_req[g] | data_break[g]), 0);

    drain(50);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
